// File: rtl/pipelined_alu_pkg.sv
// Shared types for the pipelined ALU: op encodings, flag bit positions, S1 control bundle.
package pipelined_alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD   = 3'd0,
        OP_SUB   = 3'd1,
        OP_AND   = 3'd2,
        OP_OR    = 3'd3,
        OP_XOR   = 3'd4,
        OP_PASSB = 3'd5,
        OP_NOTA  = 3'd6,
        OP_RSVD  = 3'd7
    } alu_op_t;

    localparam int FLAG_C = 3;
    localparam int FLAG_V = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_Z = 0;

    typedef struct packed {
        alu_op_t op;
        logic    ci;
    } s1_ctl_t;

endpackage

// File: rtl/pipelined_alu_core.sv
// Combinational ALU datapath between S1 and S2; produces result and {C,V,N,Z}.
module alu_core
    import pipelined_alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  alu_op_t          op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic [WIDTH-1:0] res,
    output logic [3:0]       flags
);

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum;
    logic             arith;

    always_comb begin
        b_eff = (op == OP_SUB) ? ~b : b;
        sum   = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, ci};
        arith = (op == OP_ADD) || (op == OP_SUB);

        res = '0;
        case (op)
            OP_ADD, OP_SUB: res = sum[WIDTH-1:0];
            OP_AND:         res = a & b;
            OP_OR:          res = a | b;
            OP_XOR:         res = a ^ b;
            OP_PASSB:       res = b;
            OP_NOTA:        res = ~a;
            default:        res = '0;
        endcase

        // The reserved code reports all-zero flags, including Z.
        flags = '0;
        if (op != OP_RSVD) begin
            flags[FLAG_C] = arith && sum[WIDTH];
            flags[FLAG_V] = arith && (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            flags[FLAG_N] = res[WIDTH-1];
            flags[FLAG_Z] = (res == '0);
        end
    end

endmodule

// File: rtl/pipelined_alu.sv
// Two-stage valid/ready ALU pipeline. Define PIPELINED_ALU_ACC_EN to add the
// result accumulator and its acc_sel/acc_clr inputs.
module pipelined_alu
    import pipelined_alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             ci,
`ifdef PIPELINED_ALU_ACC_EN
    input  logic             acc_sel,
    input  logic             acc_clr,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res,
    output logic [3:0]       flags
);

    logic             s2_adv;
    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_a_q, s1_a_d;
    logic [WIDTH-1:0] s1_b_q, s1_b_d;
    s1_ctl_t          s1_ctl_q, s1_ctl_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [3:0]       flags_q, flags_d;
    logic [WIDTH-1:0] core_a, core_res;
    logic [3:0]       core_flags;
`ifdef PIPELINED_ALU_ACC_EN
    logic             s1_acc_sel_q, s1_acc_sel_d;
    logic [WIDTH-1:0] acc_q, acc_d;
`endif

    alu_core #(.WIDTH(WIDTH)) u_core (
        .op    (s1_ctl_q.op),
        .a     (core_a),
        .b     (s1_b_q),
        .ci    (s1_ctl_q.ci),
        .res   (core_res),
        .flags (core_flags)
    );

    always_comb begin
        s2_adv   = !out_valid_q || out_ready;
        in_ready = !s1_valid_q || s2_adv;

        s1_valid_d = s1_valid_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_ctl_d   = s1_ctl_q;
`ifdef PIPELINED_ALU_ACC_EN
        s1_acc_sel_d = s1_acc_sel_q;
`endif
        if (in_ready) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_a_d      = op_a;
                s1_b_d      = op_b;
                s1_ctl_d.op = alu_op_t'(op);
                s1_ctl_d.ci = ci;
`ifdef PIPELINED_ALU_ACC_EN
                s1_acc_sel_d = acc_sel;
`endif
            end
        end

        // Operand A is resolved in S1, after the previous op has already updated acc_q.
`ifdef PIPELINED_ALU_ACC_EN
        core_a = s1_acc_sel_q ? acc_q : s1_a_q;
`else
        core_a = s1_a_q;
`endif

        out_valid_d = out_valid_q;
        res_d       = res_q;
        flags_d     = flags_q;
        if (s2_adv) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                res_d   = core_res;
                flags_d = core_flags;
            end
        end

`ifdef PIPELINED_ALU_ACC_EN
        acc_d = acc_q;
        if (acc_clr)
            acc_d = '0;
        else if (s2_adv && s1_valid_q)
            acc_d = core_res;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_ctl_q    <= '0;
            out_valid_q <= 1'b0;
            res_q       <= '0;
            flags_q     <= '0;
`ifdef PIPELINED_ALU_ACC_EN
            s1_acc_sel_q <= 1'b0;
            acc_q        <= '0;
`endif
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            s1_ctl_q    <= s1_ctl_d;
            out_valid_q <= out_valid_d;
            res_q       <= res_d;
            flags_q     <= flags_d;
`ifdef PIPELINED_ALU_ACC_EN
            s1_acc_sel_q <= s1_acc_sel_d;
            acc_q        <= acc_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign res       = res_q;
    assign flags     = flags_q;

endmodule

// File: tb/tb_pipelined_alu.sv
// Scoreboard bench for pipelined_alu (WIDTH=8): directed vectors, back-to-back,
// stall/hold, random backpressure, reset flush and, if enabled, the accumulator.
module tb_pipelined_alu;
    import pipelined_alu_pkg::*;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [2:0]   op = '0;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    logic         ci = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] res;
    logic [3:0]   flags;
`ifdef PIPELINED_ALU_ACC_EN
    logic         acc_sel = 1'b0;
    logic         acc_clr = 1'b0;
`endif

    always #5 clk = ~clk;

    pipelined_alu #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .op_a      (op_a),
        .op_b      (op_b),
        .ci        (ci),
`ifdef PIPELINED_ALU_ACC_EN
        .acc_sel   (acc_sel),
        .acc_clr   (acc_clr),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .res       (res),
        .flags     (flags)
    );

    typedef struct {
        logic [W-1:0] r;
        logic [3:0]   f;
        int           cyc;
        bit           lat;
    } exp_t;

    typedef struct packed {
        logic [2:0]   o;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         c;
        logic [W-1:0] r;
        logic [3:0]   f;
    } vec_t;

    // Hand-computed vectors; flags are {C,V,N,Z}.
    vec_t vecs [13] = '{
        '{3'd0, 8'hFF, 8'h01, 1'b0, 8'h00, 4'b1001},
        '{3'd1, 8'h80, 8'h01, 1'b1, 8'h7F, 4'b1100},
        '{3'd0, 8'h7F, 8'h01, 1'b0, 8'h80, 4'b0110},
        '{3'd0, 8'h12, 8'h34, 1'b1, 8'h47, 4'b0000},
        '{3'd1, 8'h05, 8'h05, 1'b1, 8'h00, 4'b1001},
        '{3'd1, 8'h03, 8'h05, 1'b1, 8'hFE, 4'b0010},
        '{3'd2, 8'hF0, 8'h3C, 1'b0, 8'h30, 4'b0000},
        '{3'd3, 8'h0F, 8'h30, 1'b0, 8'h3F, 4'b0000},
        '{3'd4, 8'hAA, 8'hAA, 1'b0, 8'h00, 4'b0001},
        '{3'd5, 8'h00, 8'hC3, 1'b0, 8'hC3, 4'b0010},
        '{3'd6, 8'h0F, 8'h55, 1'b0, 8'hF0, 4'b0010},
        '{3'd7, 8'hFF, 8'hFF, 1'b1, 8'h00, 4'b0000},
        '{3'd1, 8'h00, 8'h00, 1'b0, 8'hFF, 4'b0010}
    };

    exp_t         sb[$];
    int           n_pass = 0;
    int           n_tot = 0;
    int           cyc = 0;
    int           occ = 0;
    logic [W-1:0] cur_r = '0;
    logic [3:0]   cur_f = '0;
    bit           lat_mode = 1'b1;
    bit           rand_rdy = 1'b0;
    bit           pv_stall = 1'b0;
    logic [W-1:0] pv_res = '0;
    logic [3:0]   pv_flags = '0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference model written with signed/unsigned integer arithmetic.
    function automatic void model(input logic [2:0] o, input int a, input int b, input int c,
                                  output logic [W-1:0] r, output logic [3:0] f);
        int  s, ss, sa, sbv;
        bit  cf, vf;
        cf  = 1'b0;
        vf  = 1'b0;
        ss  = 0;
        sa  = (a >= 128) ? a - 256 : a;
        sbv = (b >= 128) ? b - 256 : b;
        case (o)
            3'd0: begin s = a + b + c;         ss = sa + sbv + c;     cf = s > 255; vf = ss > 127 || ss < -128; end
            3'd1: begin s = a + (255 - b) + c; ss = sa - sbv - 1 + c; cf = s > 255; vf = ss > 127 || ss < -128; end
            3'd2: s = a & b;
            3'd3: s = a | b;
            3'd4: s = a ^ b;
            3'd5: s = b;
            3'd6: s = 255 - a;
            default: s = 0;
        endcase
        r = W'(s & 255);
        f = (o == 3'd7) ? 4'b0000 : {cf, vf, r[W-1], r == '0};
    endfunction

    // Monitor: scoreboard pop/compare, hold-while-stalled and in_ready occupancy rule.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            sb.delete();
            occ = 0;
            pv_stall = 1'b0;
        end else begin
            if (pv_stall) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_res", res, pv_res);
                chk("hold_flags", flags, pv_flags);
            end
            chk("in_ready", in_ready, (occ < 2) || out_ready);
            chk("no_stale_out", out_valid && occ == 0, 0);
            if (out_valid && out_ready && sb.size() != 0) begin
                e = sb.pop_front();
                chk("res", res, e.r);
                chk("flags", flags, e.f);
                if (e.lat) chk("latency", cyc - e.cyc, 2);
                occ--;
            end
            if (in_valid && in_ready) begin
                sb.push_back('{cur_r, cur_f, cyc, lat_mode});
                occ++;
            end
            pv_stall = out_valid && !out_ready;
            pv_res   = res;
            pv_flags = flags;
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic c, input logic [W-1:0] er, input logic [3:0] ef);
        int  t;
        bit  done;
        t = 0;
        done = 1'b0;
        op = o; op_a = a; op_b = b; ci = c; cur_r = er; cur_f = ef;
        in_valid = 1'b1;
        while (!done) begin
            @(negedge clk);
            if (in_ready) done = 1'b1;
            else if (++t > 200) begin
                n_tot++;
                $display("FAIL accept_timeout: in_ready stuck at %0b, expected 1", in_ready);
                done = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic issue_model(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        logic [W-1:0] r;
        logic [3:0]   f;
        model(o, int'(a), int'(b), int'(c), r, f);
        issue(o, a, b, c, r, f);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 100) begin
            @(posedge clk);
            t++;
        end
        if (sb.size() != 0) begin
            n_tot++;
            $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb.size());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_res", res, 0);
        chk("rst_flags", flags, 0);
        chk("rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;

        // Directed vectors issued back-to-back with out_ready high.
        foreach (vecs[i])
            issue(vecs[i].o, vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].r, vecs[i].f);
        drain();

        // Ten back-to-back ADDs; latency check proves consecutive outputs.
        for (int i = 0; i < 10; i++)
            issue_model(3'(OP_ADD), W'(i * 3), W'(i + 1), 1'b0);
        drain();

        // Fill both stages with the consumer stalled, hold, then release.
        lat_mode = 1'b0;
        out_ready = 1'b0;
        issue_model(3'(OP_XOR), 8'h5A, 8'h0F, 1'b0);
        issue_model(3'(OP_SUB), 8'h10, 8'h20, 1'b1);
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b1;
        drain();

        // Random ops under random backpressure.
        rand_rdy = 1'b1;
        for (int i = 0; i < 300; i++)
            issue_model(3'($urandom_range(0, 7)), W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
        rand_rdy = 1'b0;
        @(posedge clk);
        #1 out_ready = 1'b1;
        drain();

`ifdef PIPELINED_ALU_ACC_EN
        // Accumulator chain: cleared, then 0+5, 5+5, 10+5 with no hazard.
        lat_mode = 1'b1;
        acc_clr = 1'b1;
        @(posedge clk);
        #1 acc_clr = 1'b0;
        acc_sel = 1'b1;
        issue(3'(OP_ADD), 8'hEE, 8'h05, 1'b0, 8'h05, 4'b0000);
        issue(3'(OP_ADD), 8'hEE, 8'h05, 1'b0, 8'h0A, 4'b0000);
        issue(3'(OP_ADD), 8'hEE, 8'h05, 1'b0, 8'h0F, 4'b0000);
        acc_sel = 1'b0;
        drain();
        lat_mode = 1'b0;
`endif

        // Reset with both stages full: nothing in flight may emerge afterwards.
        out_ready = 1'b0;
        issue_model(3'(OP_OR), 8'h81, 8'h02, 1'b0);
        issue_model(3'(OP_PASSB), 8'h00, 8'hC7, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("flush_out_valid", out_valid, 0);
        chk("flush_res", res, 0);
        chk("flush_flags", flags, 0);
        chk("flush_in_ready", in_ready, 1);
        repeat (6) @(posedge clk);
        #1;
        issue_model(3'(OP_ADD), 8'h01, 8'h02, 1'b0);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
